pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush/forwarding controller for the 5-stage rv32 pipeline (IF,ID,EXE,MEM,WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/hzd_fwd_unit.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, stage controls.
// No logic; no latency; no backpressure.
package pipe_hazard_ctrl_pkg;

    localparam int TMO_W = 8;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF     = 2'b00;
    localparam fwd_sel_t FWD_MEMWB  = 2'b01;
    localparam fwd_sel_t FWD_EXEMEM = 2'b10;

    typedef enum logic {
        HZD_RUN     = 1'b0,
        HZD_MEMWAIT = 1'b1
    } hzd_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idexe_stall;
        logic idexe_flush;
        logic exemem_stall;
        logic memwb_flush;
        logic pc_sel;
    } hzd_ctl_t;

endpackage

// File: rtl/hzd_fwd_unit.sv
// Operand forwarding select from EXE/MEM and MEM/WB destination compares; x0 never forwarded.
// Combinational, zero latency.
// No backpressure; never gated by stalls.
module hzd_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] exemem_rd,
    input  logic              exemem_wen,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_wen,
    output fwd_sel_t          sel
);

    logic hit_exemem;
    logic hit_memwb;

    assign hit_exemem = exemem_wen && (exemem_rd != '0) && (exemem_rd == src);
    assign hit_memwb  = memwb_wen  && (memwb_rd  != '0) && (memwb_rd  == src);

    // The younger EXE/MEM result wins when both stages write the same register.
    always_comb begin
        sel = FWD_RF;
        if (hit_exemem) begin
            sel = FWD_EXEMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with saturating debug counters.
// Controls are Mealy on state + inputs, zero latency; counters/flags update on the clock.
// Memory wait stalls everything up to EXE/MEM and bubbles MEM/WB until ready or timeout.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 15
) (
    input  logic              clk_i_hzd,
    input  logic              reset_i_hzd,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] idexe_rd_i,
    input  logic              idexe_memrd_i,
    input  logic [REG_AW-1:0] idexe_rs1_i,
    input  logic [REG_AW-1:0] idexe_rs2_i,
    input  logic [REG_AW-1:0] exemem_rd_i,
    input  logic              exemem_wen_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_wen_i,
    input  logic              br_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              ifid_flush_o,
    output logic              idexe_stall_o,
    output logic              idexe_flush_o,
    output logic              exemem_stall_o,
    output logic              memwb_flush_o,
    output logic              pc_sel_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    hzd_state_t       state;
    logic [TMO_W-1:0] wait_cnt;
    logic [TMO_W-1:0] wait_cnt_nxt;
    logic             mem_wait;
    logic             redirect;
    logic             load_use;
    hzd_ctl_t         ctl;
    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;

    hzd_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src        (idexe_rs1_i),
        .exemem_rd  (exemem_rd_i),
        .exemem_wen (exemem_wen_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_wen  (memwb_wen_i),
        .sel        (fwd_a)
    );

    hzd_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src        (idexe_rs2_i),
        .exemem_rd  (exemem_rd_i),
        .exemem_wen (exemem_wen_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_wen  (memwb_wen_i),
        .sel        (fwd_b)
    );

    assign load_use = idexe_memrd_i && (idexe_rd_i != '0) &&
                      ((id_use_rs1_i && (id_rs1_i == idexe_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == idexe_rd_i)));

    // A taken branch seen while memory stalls stays parked in EXE and is taken on the ready cycle.
    assign mem_wait = !mem_ready_i && (mem_req_i || (state == HZD_MEMWAIT));
    assign redirect = !mem_wait && br_taken_i;

    always_comb begin
        ctl = '0;
        if (reset_i_hzd) begin
            if (mem_wait) begin
                ctl.pc_stall     = 1'b1;
                ctl.ifid_stall   = 1'b1;
                ctl.idexe_stall  = 1'b1;
                ctl.exemem_stall = 1'b1;
                ctl.memwb_flush  = 1'b1;
            end else if (redirect) begin
                ctl.pc_sel      = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idexe_flush = 1'b1;
            end else if (load_use) begin
                ctl.pc_stall    = 1'b1;
                ctl.ifid_stall  = 1'b1;
                ctl.idexe_flush = 1'b1;
            end
        end
    end

    assign pc_stall_o     = ctl.pc_stall;
    assign ifid_stall_o   = ctl.ifid_stall;
    assign ifid_flush_o   = ctl.ifid_flush;
    assign idexe_stall_o  = ctl.idexe_stall;
    assign idexe_flush_o  = ctl.idexe_flush;
    assign exemem_stall_o = ctl.exemem_stall;
    assign memwb_flush_o  = ctl.memwb_flush;
    assign pc_sel_o       = ctl.pc_sel;
    assign fwd_a_o        = reset_i_hzd ? fwd_a : FWD_RF;
    assign fwd_b_o        = reset_i_hzd ? fwd_b : FWD_RF;

    assign wait_cnt_nxt = wait_cnt + TMO_W'(1);

    always_ff @(posedge clk_i_hzd or negedge reset_i_hzd) begin
        if (!reset_i_hzd) begin
            state       <= HZD_RUN;
            wait_cnt    <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (ctl.pc_stall && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (redirect && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
            case (state)
                HZD_RUN: begin
                    wait_cnt <= '0;
                    if (mem_req_i && !mem_ready_i) begin
                        state <= HZD_MEMWAIT;
                    end
                end
                HZD_MEMWAIT: begin
                    if (mem_ready_i) begin
                        state    <= HZD_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt_nxt == TMO_W'(MEM_TMO)) begin
                        // Give up on the access so the core cannot hang forever.
                        state     <= HZD_RUN;
                        wait_cnt  <= '0;
                        mem_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                default: begin
                    state    <= HZD_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed hazard scenarios followed by randomized traffic, checked against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int MEM_TMO = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush, exemem_stall, memwb_flush, pc_sel}
    localparam logic [7:0] C_WAIT  = 8'b1101_0110;
    localparam logic [7:0] C_REDIR = 8'b0010_1001;
    localparam logic [7:0] C_LU    = 8'b1100_1000;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, idexe_rd, idexe_rs1, idexe_rs2, exemem_rd, memwb_rd;
    logic              id_use_rs1, id_use_rs2, idexe_memrd, exemem_wen, memwb_wen;
    logic              br_taken, mem_req, mem_ready;
    logic              pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush;
    logic              exemem_stall, memwb_flush, pc_sel, mem_err;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pending;
    int m_waits;
    bit m_err;
    int m_stalls;
    int m_flushes;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
        .clk_i_hzd      (clk),
        .reset_i_hzd    (rst_n),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .idexe_rd_i     (idexe_rd),
        .idexe_memrd_i  (idexe_memrd),
        .idexe_rs1_i    (idexe_rs1),
        .idexe_rs2_i    (idexe_rs2),
        .exemem_rd_i    (exemem_rd),
        .exemem_wen_i   (exemem_wen),
        .memwb_rd_i     (memwb_rd),
        .memwb_wen_i    (memwb_wen),
        .br_taken_i     (br_taken),
        .mem_req_i      (mem_req),
        .mem_ready_i    (mem_ready),
        .pc_stall_o     (pc_stall),
        .ifid_stall_o   (ifid_stall),
        .ifid_flush_o   (ifid_flush),
        .idexe_stall_o  (idexe_stall),
        .idexe_flush_o  (idexe_flush),
        .exemem_stall_o (exemem_stall),
        .memwb_flush_o  (memwb_flush),
        .pc_sel_o       (pc_sel),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .mem_err_o      (mem_err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_ctl();
        bit waiting;
        bit lu;
        if (!rst_n) return 8'h00;
        waiting = !mem_ready && (mem_req || m_pending);
        lu = idexe_memrd && (idexe_rd != 0) &&
             ((id_use_rs1 && id_rs1 == idexe_rd) || (id_use_rs2 && id_rs2 == idexe_rd));
        if (waiting)  return C_WAIT;
        if (br_taken) return C_REDIR;
        if (lu)       return C_LU;
        return 8'h00;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] src);
        if (!rst_n) return 2'b00;
        if (exemem_wen && exemem_rd != 0 && exemem_rd == src) return 2'b10;
        if (memwb_wen && memwb_rd != 0 && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_waits   = 0;
        m_err     = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Advance the model by one clock using the inputs that were applied during the cycle.
    task automatic model_step(input logic [7:0] c);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (c[7] && m_stalls < CNT_MAX) m_stalls++;
            if (c == C_REDIR && m_flushes < CNT_MAX) m_flushes++;
            if (m_pending) begin
                if (mem_ready) begin
                    m_pending = 0;
                    m_waits   = 0;
                end else begin
                    m_waits++;
                    if (m_waits == MEM_TMO) begin
                        m_err     = 1;
                        m_pending = 0;
                        m_waits   = 0;
                    end
                end
            end else if (mem_req && !mem_ready) begin
                m_pending = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] obs;
        obs = {pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush,
               exemem_stall, memwb_flush, pc_sel};
        chk({tag, "_ctl"},   16'(obs),       16'(exp_ctl()));
        chk({tag, "_fwda"},  16'(fwd_a),     16'(exp_fwd(idexe_rs1)));
        chk({tag, "_fwdb"},  16'(fwd_b),     16'(exp_fwd(idexe_rs2)));
        chk({tag, "_err"},   16'(mem_err),   16'(m_err));
        chk({tag, "_scnt"},  16'(stall_cnt), 16'(m_stalls));
        chk({tag, "_fcnt"},  16'(flush_cnt), 16'(m_flushes));
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input string tag);
        logic [7:0] c;
        #3;
        check_all(tag);
        c = exp_ctl();
        @(posedge clk);
        model_step(c);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        idexe_rd = '0; idexe_memrd = 0; idexe_rs1 = '0; idexe_rs2 = '0;
        exemem_rd = '0; exemem_wen = 0; memwb_rd = '0; memwb_wen = 0;
        br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic pulse_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_step(8'h00);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        idexe_rs1 = 5'd3; exemem_rd = 5'd3; exemem_wen = 1; br_taken = 1; mem_req = 1;
        #4;
        check_all("reset");
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: load-use stalls exactly one cycle, then clears as the load advances
        idexe_memrd = 1; idexe_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
        cycle("t1_lu");
        chk("t1_stall_cnt", 16'(stall_cnt), 16'd1);
        idexe_memrd = 0;
        cycle("t1_adv");
        chk("t1_stall_cnt_hold", 16'(stall_cnt), 16'd1);

        // 2: forwarding priority and x0 exclusion
        set_idle();
        exemem_rd = 5'd3; exemem_wen = 1; memwb_rd = 5'd3; memwb_wen = 1; idexe_rs2 = 5'd3;
        #3;
        chk("t2_fwd_both", 16'(fwd_b), 16'b10);
        exemem_wen = 0;
        #1;
        chk("t2_fwd_memwb", 16'(fwd_b), 16'b01);
        memwb_rd = 5'd0; idexe_rs2 = 5'd0;
        #1;
        chk("t2_fwd_x0", 16'(fwd_b), 16'b00);
        @(posedge clk);
        model_step(exp_ctl());
        #1;

        // 3: redirect beats load-use
        set_idle();
        idexe_memrd = 1; idexe_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1; br_taken = 1;
        cycle("t3_redir");
        chk("t3_flush_cnt", 16'(flush_cnt), 16'd1);
        chk("t3_stall_cnt", 16'(stall_cnt), 16'd1);

        // 4: branch parked behind a 3-cycle memory wait, honoured on the ready cycle
        pulse_reset();
        br_taken = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cycle("t4_wait");
        mem_ready = 1;
        #3;
        chk("t4_ready_pcsel", 16'(pc_sel), 16'd1);
        #0;
        cycle("t4_ready");
        chk("t4_stall_cnt", 16'(stall_cnt), 16'd3);
        chk("t4_flush_cnt", 16'(flush_cnt), 16'd1);

        // 5: timeout sets a sticky error; long stall saturates the counter
        pulse_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) cycle("t5_wait");
        chk("t5_err_before", 16'(mem_err), 16'd0);
        cycle("t5_tmo");
        chk("t5_err_set", 16'(mem_err), 16'd1);
        for (int i = 0; i < 15; i++) cycle("t5_sat");
        chk("t5_stall_sat", 16'(stall_cnt), 16'(CNT_MAX));
        mem_req = 0;
        for (int i = 0; i < 3; i++) cycle("t5_idle");
        chk("t5_err_sticky", 16'(mem_err), 16'd1);

        // 6: asynchronous reset in the middle of a memory wait
        pulse_reset();
        mem_req = 1; mem_ready = 0;
        cycle("t6_pre");
        cycle("t6_pre");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_rst");
        chk("t6_rst_stall", 16'(pc_stall), 16'd0);
        rst_n = 1'b1;
        set_idle();
        @(posedge clk);
        model_step(8'h00);
        #1;
        cycle("t6_run");

        // Randomized traffic
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            id_rs1      = REG_AW'($urandom_range(0, 3));
            id_rs2      = REG_AW'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            idexe_rd    = REG_AW'($urandom_range(0, 3));
            idexe_memrd = 1'($urandom_range(0, 1));
            idexe_rs1   = REG_AW'($urandom_range(0, 3));
            idexe_rs2   = REG_AW'($urandom_range(0, 3));
            exemem_rd   = REG_AW'($urandom_range(0, 3));
            exemem_wen  = 1'($urandom_range(0, 1));
            memwb_rd    = REG_AW'($urandom_range(0, 3));
            memwb_wen   = 1'($urandom_range(0, 1));
            br_taken    = ($urandom_range(0, 5) == 0);
            mem_req     = ($urandom_range(0, 3) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
